axi_slave_mem: RTL and testbench
================================

Name: axi_slave_mem

Overview:
AXI4 memory-mapped responder (slave) backed by an internal word-addressed RAM. It terminates the M_AXI_* write and read channels driven by the team's axi burst master, so master traffic can be checked end-to-end in simulation and on FPGA. The write path (AW/W/B) and the read path (AR/R) are independent and run concurrently.

Parameters:
ADDR_WD, 32, AXI address width
DATA_WD, 32, AXI data width (8, 16, 32 or 64)
STRB_WD, DATA_WD>>3, write strobe width
MEM_AW, 10, log2 of RAM depth in words (default 1024 words)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_AWADDR  in  ADDR_WD  burst start byte address
S_AXI_AWLEN  in  8  beats minus 1
S_AXI_AWSIZE  in  3  beat size; only log2(STRB_WD) is legal
S_AXI_AWBURST  in  2  burst type
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_WDATA  in  DATA_WD  write data
S_AXI_WSTRB  in  STRB_WD  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_ARADDR  in  ADDR_WD  burst start byte address
S_AXI_ARLEN  in  8  beats minus 1
S_AXI_ARSIZE  in  3  beat size
S_AXI_ARBURST  in  2  burst type
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
S_AXI_RDATA  out  DATA_WD  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  last read beat

Behaviour:
- Single clock clk; reset is synchronous and active-high. On reset both FSMs go to IDLE, every ready/valid output and RLAST are 0, BRESP, RRESP and RDATA are 0. RAM contents are not cleared. A reset in the middle of a burst abandons that burst with no response.
- Word index = addr[MEM_AW+log2(STRB_WD)-1 : log2(STRB_WD)]. Upper address bits alias. Low byte-offset bits are ignored (aligned access).
- Next address: INCR or WRAP bursts step by one word, WRAP is treated as INCR, and the word index wraps modulo 2^MEM_AW. FIXED bursts hold the address. Reserved burst type 11, or SIZE != log2(STRB_WD), sets err. The burst still completes the full handshake, RAM writes are suppressed, read data is 0, and the response is SLVERR.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY=1. On AW handshake, latch the address, a beat counter loaded with AWLEN, and err; go to W_DATA the next cycle.
  - W_DATA: WREADY=1. Each W handshake writes the bytes whose WSTRB bit is set and advances the address, and the counter decrements.
  - WLAST must match counter==0. On a mismatch, err is set and the burst ends on the AWLEN count regardless.
  - Final beat goes to W_RESP.
  - W_RESP: BVALID=1 and BRESP = err ? SLVERR : OKAY, held until BREADY. Then W_IDLE, so AWREADY returns the cycle after the B handshake.
  - W handshakes arriving before AW are not accepted (WREADY=0 outside W_DATA).
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake, latch the address and counter, and register RDATA=mem[start]. The next cycle is R_DATA with RVALID=1, so first-beat latency is 1 cycle after the AR handshake.
  - On RVALID&&RREADY: if not last, RDATA is loaded with the next word. RVALID stays 1, giving one beat per cycle under continuous RREADY.
  - RLAST=1 on the beat where counter==0. Its handshake returns the FSM to R_IDLE.
  - With RREADY=0, RDATA, RLAST and RRESP hold stable.
- Write/read collision on the same word in the same cycle: the read register captures the old value.
- ARLEN=0 / AWLEN=0 is a single-beat burst. ARLEN=255 is 256 beats and must wrap the RAM index correctly.

Decomposition:
- Shared package axi_pkg: burst encodings (FIXED=00, INCR=01, WRAP=10) and response codes (OKAY=00, SLVERR=10). The axi master reuses these.
- Sub-module axi_slave_ram: RAM with per-byte write enable and a registered read port, parameterised by DATA_WD and MEM_AW.
- Both FSMs stay in the top module.

Test Plan:
- AW addr=0x0, len=3, INCR, WDATA 0x11111111..0x44444444, WSTRB=F, BREADY=1 -> BRESP=00. Then AR addr=0x0, len=3 -> RDATA 0x11111111..0x44444444 with RLAST on beat 4.
- Write addr=0x8, WDATA=0xAABBCCDD, WSTRB=0x5 over prior 0x0 -> read addr=0x8 returns 0x00BB00DD.
- Read len=7 with RREADY toggling 1/0 every cycle -> RDATA and RLAST stable while RREADY=0, 8 beats, no beat lost.
- AWBURST=FIXED, addr=0x10, len=2, data 1,2,3 -> read addr=0x10 returns 3. Then AWBURST=11 -> BRESP=10 and RAM is unchanged.
- WLAST asserted on beat 2 of a len=3 burst -> 4 beats accepted, BRESP=10. BREADY held 0 for 5 cycles -> BVALID holds and AWREADY stays 0.
- Reset pulsed mid read burst -> all valids 0 the next cycle. A new read of addr=0x0 returns the data written before the reset.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI4 encodings shared by the burst master and the memory responder.
package axi_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } w_state_e;

  typedef enum logic {
    RIdle,
    RData
  } r_state_e;

  // A burst is unserviceable if its type is reserved or its beat size is not the bus width.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size,
                                     input logic [2:0] beat_size);
    return (burst == BurstRsvd) || (size != beat_size);
  endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// Word-addressed RAM with per-byte write enables and a registered read port.
module axi_slave_ram #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned STRB_WD = DATA_WD >> 3,
  parameter int unsigned MEM_AW  = 10
) (
  input  logic               clk_i,
  input  logic [STRB_WD-1:0] we_i,
  input  logic [MEM_AW-1:0]  waddr_i,
  input  logic [DATA_WD-1:0] wdata_i,
  input  logic               re_i,
  input  logic [MEM_AW-1:0]  raddr_i,
  output logic [DATA_WD-1:0] rdata_o
);

  logic [DATA_WD-1:0] mem_q [2**MEM_AW];
  logic [DATA_WD-1:0] rdata_q;

  // Read samples the array before this edge's writes land, so a collision returns old data.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(STRB_WD); b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 memory responder: independent write (AW/W/B) and read (AR/R) FSMs over a shared RAM.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned STRB_WD = DATA_WD >> 3,
  parameter int unsigned MEM_AW  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               S_AXI_AWVALID,
  output logic               S_AXI_AWREADY,
  input  logic [ADDR_WD-1:0] S_AXI_AWADDR,
  input  logic [7:0]         S_AXI_AWLEN,
  input  logic [2:0]         S_AXI_AWSIZE,
  input  logic [1:0]         S_AXI_AWBURST,
  input  logic               S_AXI_WVALID,
  output logic               S_AXI_WREADY,
  input  logic [DATA_WD-1:0] S_AXI_WDATA,
  input  logic [STRB_WD-1:0] S_AXI_WSTRB,
  input  logic               S_AXI_WLAST,
  output logic               S_AXI_BVALID,
  input  logic               S_AXI_BREADY,
  output logic [1:0]         S_AXI_BRESP,
  input  logic               S_AXI_ARVALID,
  output logic               S_AXI_ARREADY,
  input  logic [ADDR_WD-1:0] S_AXI_ARADDR,
  input  logic [7:0]         S_AXI_ARLEN,
  input  logic [2:0]         S_AXI_ARSIZE,
  input  logic [1:0]         S_AXI_ARBURST,
  output logic               S_AXI_RVALID,
  input  logic               S_AXI_RREADY,
  output logic [DATA_WD-1:0] S_AXI_RDATA,
  output logic [1:0]         S_AXI_RRESP,
  output logic               S_AXI_RLAST
);

  localparam int unsigned OffW     = $clog2(STRB_WD);
  localparam logic [2:0]  BeatSize = 3'(OffW);

  w_state_e            w_state_q, w_state_d;
  logic [MEM_AW-1:0]   waddr_q, waddr_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                werr_q, werr_d;
  logic                wfixed_q, wfixed_d;

  r_state_e            r_state_q, r_state_d;
  logic [MEM_AW-1:0]   raddr_q, raddr_d;
  logic [7:0]          rcnt_q, rcnt_d;
  logic                rerr_q, rerr_d;
  logic                rfixed_q, rfixed_d;

  logic [STRB_WD-1:0]  ram_we;
  logic                ram_re;
  logic [MEM_AW-1:0]   ram_raddr;
  logic [DATA_WD-1:0]  ram_rdata;
  logic [MEM_AW-1:0]   raddr_next;

  // Only the word-index slice of each address is decoded; the rest aliases or is ignored.
  logic unused_addr;
  assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  always_comb begin
    w_state_d     = w_state_q;
    waddr_d       = waddr_q;
    wcnt_d        = wcnt_q;
    werr_d        = werr_q;
    wfixed_d      = wfixed_q;
    ram_we        = '0;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_BRESP   = RespOkay;
    unique case (w_state_q)
      WIdle: begin
        S_AXI_AWREADY = 1'b1;
        if (S_AXI_AWVALID) begin
          waddr_d   = S_AXI_AWADDR[MEM_AW+OffW-1:OffW];
          wcnt_d    = S_AXI_AWLEN;
          werr_d    = burst_err(S_AXI_AWBURST, S_AXI_AWSIZE, BeatSize);
          wfixed_d  = (S_AXI_AWBURST == BurstFixed);
          w_state_d = WData;
        end
      end
      WData: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID) begin
          if (!werr_q) begin
            ram_we = S_AXI_WSTRB;
          end
          if (!wfixed_q) begin
            waddr_d = waddr_q + MEM_AW'(1);
          end
          wcnt_d = wcnt_q - 8'd1;
          // Burst length comes from AWLEN; a misplaced WLAST only flags the response.
          if (S_AXI_WLAST != (wcnt_q == 8'd0)) begin
            werr_d = 1'b1;
          end
          if (wcnt_q == 8'd0) begin
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        S_AXI_BVALID = 1'b1;
        S_AXI_BRESP  = werr_q ? RespSlverr : RespOkay;
        if (S_AXI_BREADY) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
    if (reset) begin
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      S_AXI_BRESP   = RespOkay;
      ram_we        = '0;
    end
  end

  assign raddr_next = rfixed_q ? raddr_q : raddr_q + MEM_AW'(1);

  always_comb begin
    r_state_d     = r_state_q;
    raddr_d       = raddr_q;
    rcnt_d        = rcnt_q;
    rerr_d        = rerr_q;
    rfixed_d      = rfixed_q;
    ram_re        = 1'b0;
    ram_raddr     = raddr_q;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RLAST   = 1'b0;
    S_AXI_RRESP   = RespOkay;
    S_AXI_RDATA   = '0;
    unique case (r_state_q)
      RIdle: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) begin
          raddr_d   = S_AXI_ARADDR[MEM_AW+OffW-1:OffW];
          rcnt_d    = S_AXI_ARLEN;
          rerr_d    = burst_err(S_AXI_ARBURST, S_AXI_ARSIZE, BeatSize);
          rfixed_d  = (S_AXI_ARBURST == BurstFixed);
          ram_re    = 1'b1;
          ram_raddr = S_AXI_ARADDR[MEM_AW+OffW-1:OffW];
          r_state_d = RData;
        end
      end
      RData: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RLAST  = (rcnt_q == 8'd0);
        S_AXI_RRESP  = rerr_q ? RespSlverr : RespOkay;
        S_AXI_RDATA  = rerr_q ? '0 : ram_rdata;
        if (S_AXI_RREADY) begin
          if (rcnt_q == 8'd0) begin
            r_state_d = RIdle;
          end else begin
            // Prefetch the next beat so data streams at one beat per cycle.
            raddr_d   = raddr_next;
            rcnt_d    = rcnt_q - 8'd1;
            ram_re    = 1'b1;
            ram_raddr = raddr_next;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
    if (reset) begin
      S_AXI_ARREADY = 1'b0;
      S_AXI_RVALID  = 1'b0;
      S_AXI_RLAST   = 1'b0;
      S_AXI_RRESP   = RespOkay;
      S_AXI_RDATA   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= WIdle;
      waddr_q   <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      wfixed_q  <= 1'b0;
      r_state_q <= RIdle;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
      rfixed_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      wfixed_q  <= wfixed_d;
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      rfixed_q  <= rfixed_d;
    end
  end

  axi_slave_ram #(
    .DATA_WD(DATA_WD),
    .STRB_WD(STRB_WD),
    .MEM_AW (MEM_AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(waddr_q),
    .wdata_i(S_AXI_WDATA),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed vectors, corner sequences and random bursts against a word-array memory model.
module tb_axi_slave_mem;

  localparam int unsigned NW = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        S_AXI_AWVALID = 1'b0, S_AXI_AWREADY;
  logic [31:0] S_AXI_AWADDR = '0;
  logic [7:0]  S_AXI_AWLEN = '0;
  logic [2:0]  S_AXI_AWSIZE = 3'd2;
  logic [1:0]  S_AXI_AWBURST = 2'b01;
  logic        S_AXI_WVALID = 1'b0, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WLAST = 1'b0;
  logic        S_AXI_BVALID, S_AXI_BREADY = 1'b0;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARVALID = 1'b0, S_AXI_ARREADY;
  logic [31:0] S_AXI_ARADDR = '0;
  logic [7:0]  S_AXI_ARLEN = '0;
  logic [2:0]  S_AXI_ARSIZE = 3'd2;
  logic [1:0]  S_AXI_ARBURST = 2'b01;
  logic        S_AXI_RVALID, S_AXI_RREADY = 1'b0;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_AWADDR(S_AXI_AWADDR),
    .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_WDATA(S_AXI_WDATA),
    .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .S_AXI_RDATA(S_AXI_RDATA),
    .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST)
  );

  int total = 0;
  int bad = 0;

  // Reference memory plus a per-byte mask of which bytes hold a known value.
  logic [31:0] m_mem   [NW];
  logic [3:0]  m_known [NW];

  typedef struct {
    logic [31:0] addr;
    int          len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [31:0] d0;
    logic [31:0] dstep;
    logic [3:0]  strb;
    int          wl_beat;
    int          bdelay;
    logic [1:0]  exp_b;
    bit          chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int ch);
    case (ch)
      0:       return S_AXI_AWREADY;
      1:       return S_AXI_WREADY;
      2:       return S_AXI_BVALID;
      3:       return S_AXI_ARREADY;
      default: return S_AXI_RVALID;
    endcase
  endfunction

  task automatic wait_hi(input int ch, input string name);
    int n = 0;
    while (sig(ch) !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check({name, "_timeout"}, 64'(sig(ch)), 64'd1);
  endtask

  function automatic logic [31:0] mask32(input logic [3:0] k);
    logic [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (k[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic bit m_err(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b11) || (size != 3'd2);
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [31:0] d0, input logic [31:0] dstep,
                          input logic [3:0] strb, input bit rnd, input int wl_beat,
                          input int bdelay, output logic [1:0] bresp);
    int unsigned idx;
    bit err;
    logic [31:0] d;
    logic [3:0] s;
    idx = (addr >> 2) % NW;
    err = m_err(burst, size);
    S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len);
    S_AXI_AWBURST = burst; S_AXI_AWSIZE = size;
    wait_hi(0, "aw");
    step();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      d = rnd ? $urandom : d0 + 32'(i) * dstep;
      s = rnd ? 4'($urandom) : strb;
      S_AXI_WVALID = 1'b1; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      S_AXI_WLAST = (wl_beat >= 0) ? (i == wl_beat) : (i == len);
      wait_hi(1, "w");
      step();
      if (wl_beat >= 0) m_known[idx] = 4'h0;
      else if (!err) begin
        for (int b = 0; b < 4; b++) if (s[b]) begin
          m_mem[idx][8*b +: 8] = d[8*b +: 8];
          m_known[idx][b] = 1'b1;
        end
      end
      if (burst != 2'b00) idx = (idx + 1) % NW;
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    for (int k = 0; k < bdelay; k++) begin
      check("b_hold", 64'(S_AXI_BVALID), 64'd1);
      check("aw_blocked", 64'(S_AXI_AWREADY), 64'd0);
      step();
    end
    S_AXI_BREADY = 1'b1;
    wait_hi(2, "b");
    bresp = S_AXI_BRESP;
    step();
    S_AXI_BREADY = 1'b0;
    check("aw_after_b", 64'(S_AXI_AWREADY), 64'd1);
  endtask

  // mode: 0 = RREADY always high, 1 = toggling, 2 = random.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int mode, output logic [31:0] first);
    int unsigned idx;
    bit err, rr, stall;
    int beat, n;
    logic [31:0] pd, mk, ed;
    logic pl;
    logic [1:0] pr;
    idx = (addr >> 2) % NW;
    err = m_err(burst, size);
    beat = 0; n = 0; stall = 0; first = '0; pd = '0; pl = 1'b0; pr = '0;
    S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len);
    S_AXI_ARBURST = burst; S_AXI_ARSIZE = size;
    wait_hi(3, "ar");
    step();
    S_AXI_ARVALID = 1'b0;
    check("r_latency", 64'(S_AXI_RVALID), 64'd1);
    while (beat <= len && n < 2000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom);
      S_AXI_RREADY = rr;
      if (stall) begin
        check("r_hold_data", 64'(S_AXI_RDATA), 64'(pd));
        check("r_hold_last", 64'(S_AXI_RLAST), 64'(pl));
        check("r_hold_resp", 64'(S_AXI_RRESP), 64'(pr));
      end
      if (S_AXI_RVALID && rr) begin
        mk = err ? 32'hFFFF_FFFF : mask32(m_known[idx]);
        ed = err ? 32'h0 : m_mem[idx];
        check("r_data", 64'(S_AXI_RDATA & mk), 64'(ed & mk));
        check("r_last", 64'(S_AXI_RLAST), 64'(beat == len));
        check("r_resp", 64'(S_AXI_RRESP), err ? 64'd2 : 64'd0);
        if (beat == 0) first = S_AXI_RDATA;
        beat++;
        if (burst != 2'b00) idx = (idx + 1) % NW;
        stall = 0;
      end else begin
        stall = S_AXI_RVALID;
        pd = S_AXI_RDATA; pl = S_AXI_RLAST; pr = S_AXI_RRESP;
      end
      step();
      n++;
    end
    S_AXI_RREADY = 1'b0;
    check("r_beats", 64'(beat), 64'(len + 1));
    check("r_idle_after", 64'(S_AXI_RVALID), 64'd0);
  endtask

  initial begin
    logic [1:0] br;
    logic [31:0] rd;
    for (int i = 0; i < int'(NW); i++) begin
      m_mem[i] = '0;
      m_known[i] = 4'h0;
    end
    vecs[0] = '{32'h0,   3, 2'b01, 3'd2, 32'h11111111, 32'h11111111, 4'hF, -1, 0, 2'b00, 1, 32'h11111111};
    vecs[1] = '{32'h8,   0, 2'b01, 3'd2, 32'h0,        32'h0,        4'hF, -1, 0, 2'b00, 1, 32'h0};
    vecs[2] = '{32'h8,   0, 2'b01, 3'd2, 32'hAABBCCDD, 32'h0,        4'h5, -1, 0, 2'b00, 1, 32'h00BB00DD};
    vecs[3] = '{32'h10,  2, 2'b00, 3'd2, 32'h1,        32'h1,        4'hF, -1, 0, 2'b00, 1, 32'h3};
    vecs[4] = '{32'h10,  1, 2'b11, 3'd2, 32'hDEAD0000, 32'h1,        4'hF, -1, 0, 2'b10, 1, 32'h3};
    vecs[5] = '{32'h40,  3, 2'b01, 3'd2, 32'h5,        32'h1,        4'hF,  1, 5, 2'b10, 0, 32'h0};
    vecs[6] = '{32'h80,  1, 2'b01, 3'd1, 32'h77,       32'h1,        4'hF, -1, 0, 2'b10, 0, 32'h0};
    vecs[7] = '{32'hFF0, 7, 2'b01, 3'd2, 32'h70000000, 32'h1,        4'hF, -1, 2, 2'b00, 1, 32'h70000000};
    vecs[8] = '{32'h20,  3, 2'b10, 3'd2, 32'h9,        32'h10,       4'hF, -1, 0, 2'b00, 1, 32'h9};

    repeat (3) step();
    check("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
    check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
    reset = 1'b0;
    step();
    check("idle_awready", 64'(S_AXI_AWREADY), 64'd1);
    check("idle_arready", 64'(S_AXI_ARREADY), 64'd1);
    check("idle_bvalid", 64'(S_AXI_BVALID), 64'd0);
    check("idle_rvalid", 64'(S_AXI_RVALID), 64'd0);
    check("idle_rlast", 64'(S_AXI_RLAST), 64'd0);
    check("idle_rdata", 64'(S_AXI_RDATA), 64'd0);
    check("idle_bresp", 64'(S_AXI_BRESP), 64'd0);
    check("idle_rresp", 64'(S_AXI_RRESP), 64'd0);

    // W before AW must not be accepted.
    S_AXI_WVALID = 1'b1; S_AXI_WLAST = 1'b1; S_AXI_WSTRB = 4'hF;
    for (int k = 0; k < 3; k++) begin
      check("w_before_aw", 64'(S_AXI_WREADY), 64'd0);
      step();
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;

    for (int v = 0; v < 9; v++) begin
      do_write(vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].size, vecs[v].d0,
               vecs[v].dstep, vecs[v].strb, 1'b0, vecs[v].wl_beat, vecs[v].bdelay, br);
      check($sformatf("vec%0d_bresp", v), 64'(br), 64'(vecs[v].exp_b));
      if (vecs[v].chk) begin
        do_read(vecs[v].addr, (vecs[v].exp_b != 2'b00) ? 0 : vecs[v].len, 2'b01, 3'd2,
                v % 3, rd);
        check($sformatf("vec%0d_rd0", v), 64'(rd), 64'(vecs[v].exp_rd));
      end
    end

    do_read(32'h0, 7, 2'b01, 3'd2, 1, rd);
    do_read(32'h0, 3, 2'b11, 3'd2, 0, rd);
    do_read(32'hE10, 255, 2'b01, 3'd2, 2, rd);

    // Same-word write and read in one cycle: the read sees the pre-write value.
    do_write(32'hC00, 0, 2'b01, 3'd2, 32'h12345678, 32'h0, 4'hF, 1'b0, -1, 0, br);
    S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'hC00; S_AXI_AWLEN = 8'd0;
    S_AXI_AWBURST = 2'b01; S_AXI_AWSIZE = 3'd2;
    wait_hi(0, "aw_col");
    step();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1;
    S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 32'hC00; S_AXI_ARLEN = 8'd0;
    S_AXI_ARBURST = 2'b01; S_AXI_ARSIZE = 3'd2;
    check("col_wready", 64'(S_AXI_WREADY), 64'd1);
    check("col_arready", 64'(S_AXI_ARREADY), 64'd1);
    step();
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_ARVALID = 1'b0;
    check("col_rvalid", 64'(S_AXI_RVALID), 64'd1);
    check("col_old", 64'(S_AXI_RDATA), 64'h12345678);
    S_AXI_RREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0;
    S_AXI_BREADY = 1'b1;
    wait_hi(2, "b_col");
    check("col_bresp", 64'(S_AXI_BRESP), 64'd0);
    step();
    S_AXI_BREADY = 1'b0;
    m_mem[32'hC00 >> 2] = 32'hCAFEF00D;
    m_known[32'hC00 >> 2] = 4'hF;
    do_read(32'hC00, 0, 2'b01, 3'd2, 0, rd);
    check("col_new", 64'(rd), 64'hCAFEF00D);

    // Reset in the middle of a read burst.
    S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 32'h0; S_AXI_ARLEN = 8'd7;
    S_AXI_ARBURST = 2'b01; S_AXI_ARSIZE = 3'd2;
    wait_hi(3, "ar_rst");
    step();
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    step();
    step();
    S_AXI_RREADY = 1'b0;
    reset = 1'b1;
    step();
    check("mid_rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
    check("mid_rst_rlast", 64'(S_AXI_RLAST), 64'd0);
    check("mid_rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
    check("mid_rst_arready", 64'(S_AXI_ARREADY), 64'd0);
    check("mid_rst_rdata", 64'(S_AXI_RDATA), 64'd0);
    reset = 1'b0;
    step();
    check("post_rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
    do_read(32'h0, 3, 2'b01, 3'd2, 0, rd);
    check("post_rst_word0", 64'(rd), 64'(m_mem[0]));

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [1:0] bt;
      logic [2:0] sz;
      int ln, sel;
      a = ($urandom % NW) << 2;
      ln = int'($urandom % 16);
      sel = int'($urandom % 8);
      bt = (sel < 6) ? 2'(sel % 3) : (sel == 6) ? 2'b11 : 2'b01;
      sz = (($urandom % 8) == 0) ? 3'd1 : 3'd2;
      if (($urandom % 2) == 0) begin
        do_write(a, ln, bt, sz, 32'h0, 32'h0, 4'h0, 1'b1, -1, int'($urandom % 4), br);
        check("rnd_bresp", 64'(br), m_err(bt, sz) ? 64'd2 : 64'd0);
      end else begin
        do_read(a, ln, bt, sz, int'($urandom % 3), rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
